// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Multiplies with one shift-add step per cycle and divides with one restoring
// shift-subtract step per cycle, working on magnitudes and fixing the sign at the end.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            valid_in,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy,
  output logic            stall
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_REM    = 3'd6;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [2*XLEN-1:0]   work_q, work_d;    // {accumulator/remainder, multiplier/quotient}
  logic [XLEN-1:0]     divs_q, divs_d;    // multiplicand or divisor magnitude
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                rv_q, rv_d;
  logic                busy_q, busy_d;

  // Operand decode signals
  logic                is_m_s;
  logic                accept_s;
  logic                a_signed_s, b_signed_s;
  logic                neg_a_s, neg_b_s;
  logic [XLEN-1:0]     abs_a_s, abs_b_s;
  logic                neg_in_s;
  logic                div_zero_s, div_ovf_s;
  logic [XLEN-1:0]     special_s;

  // Iteration datapath signals
  logic [XLEN:0]       add_s;
  logic [XLEN:0]       rem_sh_s;
  logic [XLEN:0]       diff_s;
  logic [2*XLEN-1:0]   mul_step_s, div_step_s, step_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     mul_res_s, div_sel_s, div_res_s, final_s;

  assign is_m_s   = valid_in & (alu_op[4:3] == 2'b01);
  assign accept_s = (state_q == S_IDLE) & is_m_s & ~flush;

  // Decode operand signedness from funct3
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (alu_op[2:0])
      F3_MULH, F3_DIV, F3_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      F3_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
  end

  assign neg_a_s  = a_signed_s & operand_a[XLEN-1];
  assign neg_b_s  = b_signed_s & operand_b[XLEN-1];
  assign abs_a_s  = neg_a_s ? (~operand_a + {{(XLEN-1){1'b0}}, 1'b1}) : operand_a;
  assign abs_b_s  = neg_b_s ? (~operand_b + {{(XLEN-1){1'b0}}, 1'b1}) : operand_b;
  // Remainder follows the dividend; products and quotients follow the sign xor.
  assign neg_in_s = (alu_op[2:0] == F3_REM) ? neg_a_s : (neg_a_s ^ neg_b_s);

  // Divide-by-zero and signed overflow never enter the iterative loop.
  assign div_zero_s = alu_op[2] & (operand_b == ZERO);
  assign div_ovf_s  = alu_op[2] & ~alu_op[0] & (operand_a == INT_MIN) & (operand_b == ALL_ONES);
  assign special_s  = div_zero_s ? (alu_op[1] ? operand_a : ALL_ONES)
                                 : (alu_op[1] ? ZERO      : INT_MIN);

  // One multiply or divide iteration on the working register
  always_comb begin
    add_s      = {1'b0, work_q[2*XLEN-1:XLEN]} +
                 (work_q[0] ? {1'b0, divs_q} : {(XLEN+1){1'b0}});
    mul_step_s = {add_s, work_q[XLEN-1:1]};
    rem_sh_s   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    diff_s     = rem_sh_s - {1'b0, divs_q};
    if (diff_s[XLEN]) begin
      div_step_s = {rem_sh_s[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
    end else begin
      div_step_s = {diff_s[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
    end
    step_s = op_q[2] ? div_step_s : mul_step_s;
  end

  // Sign correction and result selection applied to the final iteration
  always_comb begin
    prod_s    = neg_q ? (~step_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : step_s;
    mul_res_s = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_sel_s = op_q[1] ? step_s[2*XLEN-1:XLEN] : step_s[XLEN-1:0];
    div_res_s = neg_q ? (~div_sel_s + {{(XLEN-1){1'b0}}, 1'b1}) : div_sel_s;
    final_s   = op_q[2] ? div_res_s : mul_res_s;
  end

  // Next-state and datapath control for IDLE -> CALC -> DONE
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    divs_d   = divs_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    rv_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d   = alu_op[2:0];
          neg_d  = neg_in_s;
          work_d = {ZERO, abs_a_s};
          divs_d = abs_b_s;
          cnt_d  = {CW{1'b0}};
          if (div_zero_s | div_ovf_s) begin
            state_d  = S_DONE;
            result_d = special_s;
            rv_d     = 1'b1;
          end else begin
            state_d  = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          work_d = step_s;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_d == CW'(XLEN)) begin
            state_d  = S_DONE;
            result_d = final_s;
            rv_d     = 1'b1;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      work_q   <= {(2*XLEN){1'b0}};
      divs_q   <= ZERO;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      result_q <= ZERO;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      divs_q   <= divs_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
    end
  end

  assign result       = result_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  // Stall must react in the same cycle the M op arrives, so it stays combinational.
  assign stall        = is_m_s & ~rv_q & ~flush;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit, checked against a
// transaction-level reference model and hand-computed literal results.
module tb_mul_div_unit;

  localparam int XLEN = 32;

  logic        CLK;
  logic        RESET;
  logic        valid_in;
  logic [4:0]  alu_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .valid_in     (valid_in),
    .alu_op       (alu_op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .stall        (stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'd0;
    case (f3)
      3'd0: begin p = ua * ub;             r = p[31:0];  end
      3'd1: begin p = sa * sb;             r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub);   r = p[63:32]; end
      3'd3: begin p = ua * ub;             r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0)  r = 32'hFFFF_FFFF;
        else if (ovf)    r = 32'h8000_0000;
        else             r = 32'($signed(a) / $signed(b));
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0)  r = a;
        else if (ovf)    r = 32'd0;
        else             r = 32'($signed(a) % $signed(b));
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
                     (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Transaction model: an accepted op produces its result after XLEN+1 edges
  // (or 1 edge for the bypass cases), then the unit idles for one edge.
  bit          m_busy, m_rv;
  int          m_left;
  logic [31:0] m_res, m_pend;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_busy <= 1'b0;
      m_rv   <= 1'b0;
      m_left <= 0;
      m_res  <= 32'd0;
      m_pend <= 32'd0;
    end else if (!m_busy) begin
      m_rv <= 1'b0;
      if (valid_in && alu_op[4:3] == 2'b01 && !flush) begin
        m_busy <= 1'b1;
        m_pend <= ref_model(alu_op[2:0], operand_a, operand_b);
        if (is_special(alu_op[2:0], operand_a, operand_b)) begin
          m_rv   <= 1'b1;
          m_res  <= ref_model(alu_op[2:0], operand_a, operand_b);
          m_left <= 0;
        end else begin
          m_left <= XLEN;
        end
      end
    end else if (m_rv || flush) begin
      m_busy <= 1'b0;
      m_rv   <= 1'b0;
    end else if (m_left == 1) begin
      m_rv   <= 1'b1;
      m_res  <= m_pend;
      m_left <= 0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge CLK) begin
    if (!RESET && checking) begin
      chk("cmp_result_valid", 32'(result_valid), 32'(m_rv));
      chk("cmp_busy", 32'(busy), 32'(m_busy));
      chk("cmp_stall", 32'(stall),
          32'(valid_in && alu_op[4:3] == 2'b01 && !m_rv && !flush));
      chk("cmp_result", result, m_res);
    end
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Caller sits just after a rising edge; ends just after the edge following DONE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int stall_cnt;
    bit seen;
    chk("model_pin", ref_model(f3, a, b), exp);
    valid_in  = 1'b1;
    alu_op    = {2'b01, f3};
    operand_a = a;
    operand_b = b;
    #1;
    stall_cnt = stall ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      @(posedge CLK);
      #1;
      lat++;
      if (lat == 5) begin
        operand_a = ~a;
        operand_b = a ^ b;
      end
      if (stall) stall_cnt++;
      if (result_valid) seen = 1'b1;
    end
    chk("result_valid_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result_literal", result, exp);
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_lat));
    @(posedge CLK);
    #1;
    valid_in = 1'b0;
    alu_op   = 5'd0;
  endtask

  initial begin
    bit          rv_seen;
    logic [31:0] last_res;

    RESET     = 1'b1;
    valid_in  = 1'b0;
    alu_op    = 5'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    flush     = 1'b0;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        33});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         33});
    vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd7, 32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         33});
    vecs.push_back('{3'd1, 32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1});

    // Reset state
    #3;
    chk("reset_result", result, 32'd0);
    chk("reset_result_valid", 32'(result_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    #9;
    RESET    = 1'b0;
    checking = 1'b1;
    @(posedge CLK);
    #1;

    // Directed vectors, issued back to back
    last_res = 32'd0;
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      last_res = vecs[i].exp;
    end

    // Flush in the middle of CALC
    valid_in  = 1'b1;
    alu_op    = {2'b01, 3'd0};
    operand_a = 32'd5;
    operand_b = 32'd6;
    rv_seen   = 1'b0;
    repeat (11) begin
      @(posedge CLK);
      #1;
      if (result_valid) rv_seen = 1'b1;
    end
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush    = 1'b0;
    valid_in = 1'b0;
    alu_op   = 5'd0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result_hold", result, last_res);
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (result_valid) rv_seen = 1'b1;
    end
    chk("flush_no_pulse", 32'(rv_seen), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33);

    // Asynchronous reset in the middle of CALC
    valid_in  = 1'b1;
    alu_op    = {2'b01, 3'd0};
    operand_a = 32'd9;
    operand_b = 32'd9;
    repeat (10) @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk("async_reset_result", result, 32'd0);
    chk("async_reset_result_valid", 32'(result_valid), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    alu_op = 5'b00000;
    #1;
    chk("non_m_stall", 32'(stall), 32'd0);
    #2;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("non_m_idle_busy", 32'(busy), 32'd0);
    chk("non_m_idle_stall", 32'(stall), 32'd0);
    valid_in = 1'b0;
    @(posedge CLK);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
